// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, phases,
// ALU codes, per-opcode execute lengths and the datapath control word.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_OUT  = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = OP_ADD;
  localparam logic [4:0] ALU_AND  = OP_AND;
  localparam logic [4:0] ALU_OR   = OP_OR;

  localparam logic [2:0] STEPS_RTYPE  = 3'd3;
  localparam logic [2:0] STEPS_IMM    = 3'd3;
  localparam logic [2:0] STEPS_UNARY  = 3'd2;
  localparam logic [2:0] STEPS_MULDIV = 3'd4;
  localparam logic [2:0] STEPS_LD     = 3'd5;
  localparam logic [2:0] STEPS_LDI    = 3'd3;
  localparam logic [2:0] STEPS_ST     = 3'd5;
  localparam logic [2:0] STEPS_BR     = 3'd4;
  localparam logic [2:0] STEPS_JAL    = 3'd2;
  localparam logic [2:0] STEPS_SINGLE = 3'd1;

  typedef enum logic [2:0] {
    RESET_ST, FETCH0, FETCH1, FETCH2, EXEC, HALT
  } phase_t;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       zhigh_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       inport_out;
    logic       ba_out;
    logic       c_out;
    logic       r_out;
    logic       pc_en;
    logic       inc_pc;
    logic       mar_en;
    logic       mdr_en;
    logic       mdr_read;
    logic       ir_en;
    logic       y_en;
    logic       zlow_in;
    logic       zhigh_in;
    logic       hi_en;
    logic       lo_en;
    logic       r_in;
    logic       con_en;
    logic       outport_en;
    logic       ram_write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic [4:0] alu_sel;
  } ctrl_word_t;

  function automatic logic [2:0] step_count(input logic [4:0] op);
    case (op) inside
      [OP_ADD:OP_ROL]:           return STEPS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:  return STEPS_IMM;
      OP_NEG, OP_NOT:            return STEPS_UNARY;
      OP_MUL, OP_DIV:            return STEPS_MULDIV;
      OP_LD:                     return STEPS_LD;
      OP_LDI:                    return STEPS_LDI;
      OP_ST:                     return STEPS_ST;
      OP_BR:                     return STEPS_BR;
      OP_JAL:                    return STEPS_JAL;
      default:                   return STEPS_SINGLE;
    endcase
  endfunction

  // The ALU code is held for the whole execute sequence of an opcode.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op) inside
      [OP_ADD:OP_ROL], OP_MUL, OP_DIV, OP_NEG, OP_NOT: return op;
      OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR:            return ALU_ADD;
      OP_ANDI:                                         return ALU_AND;
      OP_ORI:                                          return ALU_OR;
      default:                                         return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_exec_decoder.sv
// Execute-phase decode: (opcode, step, branch flag) -> control word for one
// T3..T7 cycle, plus a flag marking the opcode's final step.
module exec_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] step,
  input  logic       con_ff,
  output ctrl_word_t cw,
  output logic       last_step
);

  always_comb begin
    // NOTE: every field gets a default before the case so that no path leaves
    // a strobe unassigned, which would infer a latch.
    cw         = '0;
    cw.alu_sel = alu_code(opcode);
    case (opcode) inside
      [OP_ADD:OP_ROL]: begin
        case (step)
          3'd0:    begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_en = 1'b1; end
          3'd1:    begin cw.grc = 1'b1; cw.r_out = 1'b1; cw.zlow_in = 1'b1; end
          3'd2:    begin cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        case (step)
          3'd0:    begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.y_en = 1'b1; end
          3'd1:    begin cw.c_out = 1'b1; cw.zlow_in = 1'b1; end
          3'd2:    begin cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
          default: ;
        endcase
      end
      OP_NEG, OP_NOT: begin
        case (step)
          3'd0:    begin cw.grb = 1'b1; cw.r_out = 1'b1; cw.zlow_in = 1'b1; end
          3'd1:    begin cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
          default: ;
        endcase
      end
      OP_MUL, OP_DIV: begin
        case (step)
          3'd0: begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.y_en = 1'b1; end
          3'd1: begin
            cw.grb = 1'b1; cw.r_out = 1'b1; cw.zlow_in = 1'b1; cw.zhigh_in = 1'b1;
          end
          3'd2:    begin cw.zlow_out = 1'b1; cw.lo_en = 1'b1; end
          3'd3:    begin cw.zhigh_out = 1'b1; cw.hi_en = 1'b1; end
          default: ;
        endcase
      end
      // ld, ldi and st share the effective-address computation in T3..T4.
      OP_LD, OP_LDI, OP_ST: begin
        case (step)
          3'd0: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_en = 1'b1; end
          3'd1: begin cw.c_out = 1'b1; cw.zlow_in = 1'b1; end
          3'd2: begin
            cw.zlow_out = 1'b1;
            if (opcode == OP_LDI) begin
              cw.gra  = 1'b1;
              cw.r_in = 1'b1;
            end else begin
              cw.mar_en = 1'b1;
            end
          end
          3'd3: begin
            if (opcode == OP_ST) begin
              cw.gra = 1'b1; cw.r_out = 1'b1; cw.mdr_en = 1'b1;
            end else if (opcode == OP_LD) begin
              cw.mdr_read = 1'b1; cw.mdr_en = 1'b1;
            end
          end
          3'd4: begin
            if (opcode == OP_ST) begin
              cw.ram_write = 1'b1;
            end else if (opcode == OP_LD) begin
              cw.mdr_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_BR: begin
        case (step)
          3'd0:    begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.con_en = 1'b1; end
          3'd1:    begin cw.pc_out = 1'b1; cw.y_en = 1'b1; end
          3'd2:    begin cw.c_out = 1'b1; cw.zlow_in = 1'b1; end
          3'd3:    begin cw.zlow_out = 1'b1; cw.pc_en = con_ff; end
          default: ;
        endcase
      end
      OP_JR: begin
        cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_en = 1'b1;
      end
      OP_JAL: begin
        case (step)
          3'd0:    begin cw.pc_out = 1'b1; cw.grb = 1'b1; cw.r_in = 1'b1; end
          3'd1:    begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.pc_en = 1'b1; end
          default: ;
        endcase
      end
      OP_IN:   begin cw.inport_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
      OP_OUT:  begin cw.gra = 1'b1; cw.r_out = 1'b1; cw.outport_en = 1'b1; end
      OP_MFHI: begin cw.hi_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
      OP_MFLO: begin cw.lo_out = 1'b1; cw.gra = 1'b1; cw.r_in = 1'b1; end
      default: ;
    endcase
  end

  assign last_step = (step == step_count(opcode) - 3'd1);

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: phase/step registers, fetch decode and the
// mapping of the control word onto the datapath strobes.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int RESET_IDLE_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        BAout,
  output logic        Cout,
  output logic        R_out,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        MDR_read,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        R_in,
  output logic        CON_enable,
  output logic        OutPort_enable,
  output logic        RAM_write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  ALU_sel,
  output logic        Run
);

  localparam int IDLE_W = (RESET_IDLE_CYCLES > 1) ? $clog2(RESET_IDLE_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RESET_IDLE_CYCLES - 1);

  phase_t            phase, phase_nxt;
  logic [2:0]        step, step_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [4:0]        opcode;
  ctrl_word_t        exec_cw, cw;
  logic              last_step;
  logic              unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  exec_decoder u_exec_decoder (
    .opcode    (opcode),
    .step      (step),
    .con_ff    (CON_FF),
    .cw        (exec_cw),
    .last_step (last_step)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    if (!Clear) begin
      phase    <= RESET_ST;
      step     <= '0;
      idle_cnt <= '0;
    end else begin
      phase    <= phase_nxt;
      step     <= step_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    step_nxt  = step;
    idle_nxt  = idle_cnt;
    case (phase)
      RESET_ST: begin
        if (idle_cnt == IDLE_LAST) phase_nxt = FETCH0;
        else                       idle_nxt  = idle_cnt + 1'b1;
      end
      FETCH0: phase_nxt = FETCH1;
      FETCH1: phase_nxt = FETCH2;
      FETCH2: begin
        phase_nxt = EXEC;
        step_nxt  = '0;
      end
      EXEC: begin
        if (opcode == OP_HALT) begin
          phase_nxt = HALT;
        end else if (last_step) begin
          phase_nxt = FETCH0;
          step_nxt  = '0;
        end else begin
          step_nxt = step + 3'd1;
        end
      end
      HALT:    ;
      default: phase_nxt = RESET_ST;
    endcase
  end

  // Because the reset phase decodes to an all-zero word, Clear silences every
  // strobe asynchronously.
  always_comb begin
    cw = '0;
    case (phase)
      FETCH0: begin cw.pc_out = 1'b1; cw.mar_en = 1'b1; cw.inc_pc = 1'b1; cw.zlow_in = 1'b1; end
      FETCH1: begin cw.zlow_out = 1'b1; cw.pc_en = 1'b1; cw.mdr_read = 1'b1; cw.mdr_en = 1'b1; end
      FETCH2: begin cw.mdr_out = 1'b1; cw.ir_en = 1'b1; end
      EXEC:    cw = exec_cw;
      default: ;
    endcase
  end

  assign Run = (phase != RESET_ST) && (phase != HALT);

  assign PCout          = cw.pc_out;
  assign ZLowout        = cw.zlow_out;
  assign ZHighout       = cw.zhigh_out;
  assign MDRout         = cw.mdr_out;
  assign HIout          = cw.hi_out;
  assign LOout          = cw.lo_out;
  assign InPortout      = cw.inport_out;
  assign BAout          = cw.ba_out;
  assign Cout           = cw.c_out;
  assign R_out          = cw.r_out;
  assign PC_enable      = cw.pc_en;
  assign IncPC          = cw.inc_pc;
  assign MAR_enable     = cw.mar_en;
  assign MDR_enable     = cw.mdr_en;
  assign MDR_read       = cw.mdr_read;
  assign IR_enable      = cw.ir_en;
  assign Y_enable       = cw.y_en;
  assign ZLowIn         = cw.zlow_in;
  assign ZHighIn        = cw.zhigh_in;
  assign HI_enable      = cw.hi_en;
  assign LO_enable      = cw.lo_en;
  assign R_in           = cw.r_in;
  assign CON_enable     = cw.con_en;
  assign OutPort_enable = cw.outport_en;
  assign RAM_write      = cw.ram_write;
  assign Gra            = cw.gra;
  assign Grb            = cw.grb;
  assign Grc            = cw.grc;
  assign ALU_sel        = cw.alu_sel;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a queue-of-control-words model checked every cycle,
// plus directed literal expectations for the key sequences.
module tb_control_unit;

  localparam int IDLE = 1;

  localparam logic [27:0] PCO  = 28'h0000001, ZLO  = 28'h0000002, ZHO  = 28'h0000004;
  localparam logic [27:0] MDRO = 28'h0000008, HIO  = 28'h0000010, LOO  = 28'h0000020;
  localparam logic [27:0] INO  = 28'h0000040, BAO  = 28'h0000080, CO   = 28'h0000100;
  localparam logic [27:0] RO   = 28'h0000200, PCE  = 28'h0000400, INC  = 28'h0000800;
  localparam logic [27:0] MARE = 28'h0001000, MDRE = 28'h0002000, MDRR = 28'h0004000;
  localparam logic [27:0] IRE  = 28'h0008000, YE   = 28'h0010000, ZLI  = 28'h0020000;
  localparam logic [27:0] ZHI  = 28'h0040000, HIE  = 28'h0080000, LOE  = 28'h0100000;
  localparam logic [27:0] RI   = 28'h0200000, CONE = 28'h0400000, OUTE = 28'h0800000;
  localparam logic [27:0] RAMW = 28'h1000000, GA   = 28'h2000000, GB   = 28'h4000000;
  localparam logic [27:0] GC   = 28'h8000000;
  localparam logic [27:0] F0M  = PCO | MARE | INC | ZLI;

  localparam logic [1:0] TAG_NONE = 2'd0, TAG_FETCH_END = 2'd1, TAG_HALT = 2'd2;

  typedef struct packed {
    logic [1:0]  tag;
    logic        run;
    logic        cond;
    logic [4:0]  alu;
    logic [27:0] m;
  } exp_t;

  logic        Clock, Clear, CON_FF;
  logic [31:0] IR;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout, R_out;
  logic PC_enable, IncPC, MAR_enable, MDR_enable, MDR_read, IR_enable, Y_enable;
  logic ZLowIn, ZHighIn, HI_enable, LO_enable, R_in, CON_enable, OutPort_enable;
  logic RAM_write, Gra, Grb, Grc, Run;
  logic [4:0]  ALU_sel;
  logic [27:0] act;

  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 0;
  bit   halted   = 0;
  exp_t cur      = '0;
  exp_t q[$];

  control_unit #(.RESET_IDLE_CYCLES(IDLE)) dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .BAout(BAout),
    .Cout(Cout), .R_out(R_out), .PC_enable(PC_enable), .IncPC(IncPC),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .MDR_read(MDR_read),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .R_in(R_in),
    .CON_enable(CON_enable), .OutPort_enable(OutPort_enable), .RAM_write(RAM_write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALU_sel(ALU_sel), .Run(Run)
  );

  assign act = {Grc, Grb, Gra, RAM_write, OutPort_enable, CON_enable, R_in, LO_enable,
                HI_enable, ZHighIn, ZLowIn, Y_enable, IR_enable, MDR_read, MDR_enable,
                MAR_enable, IncPC, PC_enable, R_out, Cout, BAout, InPortout, LOout,
                HIout, MDRout, ZHighout, ZLowout, PCout};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [4:0] alu_for(input logic [4:0] op);
    if ((op >= 5'd3 && op <= 5'd11) || (op >= 5'd15 && op <= 5'd18)) return op;
    if (op == 5'd13) return 5'b00101;
    if (op == 5'd14) return 5'b00110;
    if (op <= 5'd2 || op == 5'd12 || op == 5'd19) return 5'b00011;
    return 5'b00000;
  endfunction

  task automatic push(input logic [27:0] m, input logic [4:0] alu,
                      input logic cond = 1'b0, input logic [1:0] tag = TAG_NONE);
    exp_t e;
    e.tag = tag; e.run = 1'b1; e.cond = cond; e.alu = alu; e.m = m;
    q.push_back(e);
  endtask

  task automatic push_fetch();
    push(F0M, 5'd0);
    push(ZLO | PCE | MDRR | MDRE, 5'd0);
    push(MDRO | IRE, 5'd0, 1'b0, TAG_FETCH_END);
  endtask

  task automatic push_exec(input logic [4:0] op);
    logic [4:0] a;
    a = alu_for(op);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(GB | RO | YE, a); push(GC | RO | ZLI, a); push(ZLO | GA | RI, a);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(GB | RO | YE, a); push(CO | ZLI, a); push(ZLO | GA | RI, a);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(GB | RO | ZLI, a); push(ZLO | GA | RI, a);
    end else if (op == 5'd15 || op == 5'd16) begin
      push(GA | RO | YE, a); push(GB | RO | ZLI | ZHI, a);
      push(ZLO | LOE, a); push(ZHO | HIE, a);
    end else if (op <= 5'd2) begin
      push(GB | BAO | YE, a); push(CO | ZLI, a);
      if (op == 5'd1) push(ZLO | GA | RI, a);
      else begin
        push(ZLO | MARE, a);
        if (op == 5'd0) begin push(MDRR | MDRE, a); push(MDRO | GA | RI, a); end
        else begin push(GA | RO | MDRE, a); push(RAMW, a); end
      end
    end else begin
      case (op)
        5'd19: begin
          push(GA | RO | CONE, a); push(PCO | YE, a); push(CO | ZLI, a);
          push(ZLO, a, 1'b1);
        end
        5'd20: push(GA | RO | PCE, a);
        5'd21: begin push(PCO | GB | RI, a); push(GA | RO | PCE, a); end
        5'd22: push(INO | GA | RI, a);
        5'd23: push(HIO | GA | RI, a);
        5'd24: push(LOO | GA | RI, a);
        5'd25: push(GA | RO | OUTE, a);
        5'd27: push(28'd0, a, 1'b0, TAG_HALT);
        default: push(28'd0, a);
      endcase
    end
  endtask

  // Model: one expected control word per clock, consumed from a queue that is
  // refilled with a fetch triple or the opcode's execute list.
  initial begin
    forever begin
      @(posedge Clock or negedge Clear);
      if (!Clear) begin
        halted = 0;
        cur    = '0;
        q.delete();
        for (int i = 1; i < IDLE; i++) q.push_back('0);
      end else if (halted) begin
        cur = '0;
      end else if (cur.tag == TAG_HALT) begin
        halted = 1;
        cur    = '0;
      end else begin
        if (q.size() == 0) begin
          if (cur.tag == TAG_FETCH_END) push_exec(IR[31:27]);
          else                          push_fetch();
        end
        cur = q.pop_front();
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("cycle", {29'd0, Run, ALU_sel, act},
            {29'd0, cur.run, cur.alu, cur.m | ((cur.cond && CON_FF) ? PCE : 28'd0)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  int unsigned lens [32] = '{5,3,5, 3,3,3,3,3,3,3,3,3, 3,3,3, 4,4, 2,2, 4, 1, 2,
                             1,1,1,1,1, 1, 1,1,1,1};

  initial begin
    Clear  = 1'b1;
    IR     = 32'hB9000000;
    CON_FF = 1'b0;
    #1 Clear = 1'b0;
    #1 chk_en = 1;

    repeat (3) @(negedge Clock);
    check("reset_quiet", {Run, ALU_sel, act}, 34'd0);
    Clear = 1'b1;
    #1 check("reset_idle_run", {63'd0, Run}, 64'd0);
    @(negedge Clock);
    check("t0_fetch", {Run, act}, {1'b1, F0M});

    // mfhi
    repeat (3) @(negedge Clock);
    check("mfhi_t3", act, HIO | GA | RI);
    @(negedge Clock);
    check("mfhi_next_t0", act, F0M);

    // add: T0..T5 then T0
    IR = 32'h18000000;
    repeat (4) @(negedge Clock);
    check("add_alu_t4", ALU_sel, 5'b00011);
    check("add_t4", act, GC | RO | ZLI);
    repeat (2) @(negedge Clock);
    check("add_len", act, F0M);

    // st
    IR = 32'h10000000;
    repeat (6) @(negedge Clock);
    check("st_t6_mdr", {MDR_read, MDR_enable}, 2'b01);
    @(negedge Clock);
    check("st_t7_ramw", RAM_write, 1'b1);
    @(negedge Clock);
    check("st_after_ramw", {RAM_write, PCout}, 2'b01);

    // br not taken, with CON_FF high before T6
    IR = 32'h98000000; CON_FF = 1'b1;
    repeat (3) @(negedge Clock);
    check("br0_t3_con", CON_enable, 1'b1);
    repeat (2) @(negedge Clock);
    CON_FF = 1'b0;
    @(negedge Clock);
    check("br0_t6", {ZLowout, PC_enable}, 2'b10);
    @(negedge Clock);
    // br taken
    repeat (3) @(negedge Clock);
    check("br1_t3_con", CON_enable, 1'b1);
    repeat (2) @(negedge Clock);
    CON_FF = 1'b1;
    @(negedge Clock);
    check("br1_t6", {ZLowout, PC_enable}, 2'b11);
    CON_FF = 1'b0;
    @(negedge Clock);
    check("br1_next_t0", act, F0M);

    // every other opcode, random register fields; model checks each cycle
    for (int op = 0; op < 32; op++) begin
      if (op != 27) begin
        IR     = {op[4:0], 27'($urandom)};
        CON_FF = 1'($urandom_range(0, 1));
        repeat (3 + lens[op]) @(negedge Clock);
        check("seq_len", {27'd0, op[4:0], act}, {27'd0, op[4:0], F0M});
      end
    end
    CON_FF = 1'b0;

    // Clear mid ld T6
    IR = 32'h00000000;
    repeat (6) @(negedge Clock);
    check("ld_t6", act, MDRR | MDRE);
    #2 Clear = 1'b0;
    #1 check("clear_async", {Run, ALU_sel, act}, 34'd0);
    repeat (2) @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    check("clear_restart", act, F0M);

    // halt
    IR = 32'hD8000000;
    repeat (3) @(negedge Clock);
    check("halt_t3_run", Run, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check("halt_hold", {Run, ALU_sel, act}, 34'd0);
    end
    Clear = 1'b0;
    @(negedge Clock);
    Clear = 1'b1;
    IR = 32'hD0000000;
    @(negedge Clock);
    check("halt_exit", {Run, act}, {1'b1, F0M});
    repeat (4) @(negedge Clock);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
